// File: rtl/mmio_hub_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mmio_hub_pkg
// Desc     : Register-window constants and helpers shared by the MMIO
//            player hub and its button debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_hub_pkg;

    // Size of the hub window in dmem words
    localparam int WINDOW_WORDS = 512;

    // Word offsets inside the hub window
    localparam logic [8:0] OFF_STATE  = 9'h000;
    localparam logic [8:0] OFF_BTN    = 9'h100;
    localparam logic [8:0] OFF_COMMIT = 9'h180;
    localparam logic [8:0] OFF_FRAME  = 9'h181;
    localparam logic [8:0] OFF_GPIO   = 9'h182;

    // Button status word: sticky press edges in the upper half, level below
    function automatic logic [31:0] pack_btn(input logic [15:0] level,
                                             input logic [15:0] edges);
        return {edges, level};
    endfunction

endpackage : mmio_hub_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Desc     : Per-bit 2-flop synchroniser, stability counter, debounced level
//            and sticky rising-edge flags with write-one-to-clear.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int BTN_W        = 8,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [BTN_W-1:0] btn_raw,
    input  logic [BTN_W-1:0] clr,
    output logic [BTN_W-1:0] level,
    output logic [BTN_W-1:0] edges
);

    // Counter only needs to reach DEBOUNCE_CYC-1; the accepting cycle clears it
    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

    logic [BTN_W-1:0]   r_meta;
    logic [BTN_W-1:0]   r_sync;
    logic [BTN_W-1:0]   r_level;
    logic [BTN_W-1:0]   r_edges;
    logic [c_CNT_W-1:0] r_cnt [BTN_W];
    logic [BTN_W-1:0]   w_expire;

    // A bit is accepted on the cycle its sync value has differed DEBOUNCE_CYC times
    always_comb begin
        w_expire = '0;
        for (int b = 0; b < BTN_W; b++) begin
            w_expire[b] = (r_sync[b] != r_level[b]) && (r_cnt[b] == c_CNT_LAST);
        end
    end

    // Synchroniser, stability counters, level toggle and sticky edges
    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta  <= '0;
            r_sync  <= '0;
            r_level <= '0;
            r_edges <= '0;
            for (int b = 0; b < BTN_W; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            r_meta  <= btn_raw;
            r_sync  <= r_meta;
            r_level <= r_level ^ w_expire;
            // A new press beats a same-cycle clear
            r_edges <= (r_edges & ~clr) | (w_expire & r_sync);
            for (int b = 0; b < BTN_W; b++) begin
                if ((r_sync[b] == r_level[b]) || w_expire[b]) begin
                    r_cnt[b] <= '0;
                end else begin
                    r_cnt[b] <= r_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign level = r_level;
    assign edges = r_edges;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/mmio_player_hub.sv
`default_nettype none
// ============================================================================
// Module   : mmio_player_hub
// Desc     : Memory-mapped hub for N players: debounced buttons, shadow/front
//            sprite-state banks swapped at vsync, frame counter, gpio output.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_player_hub
    import mmio_hub_pkg::*;
#(
    parameter int                NUM_PLAYERS  = 2,
    parameter int                STATE_WORDS  = 4,
    parameter int                BTN_W        = 8,
    parameter int                GPIO_W       = 36,
    parameter int                GPIO_OUT_W   = 3,
    parameter int                DEBOUNCE_CYC = 50000,
    parameter int                ADDR_W       = 13,
    parameter logic [ADDR_W-1:0] IO_BASE      = 13'h1000
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [ADDR_W-1:0]                      address,
    input  logic [31:0]                            data_in,
    input  logic                                   wren,
    output logic [31:0]                            data_out,
    output logic                                   hit,
    input  logic [GPIO_W-1:0]                      gpio,
    input  logic                                   vsync_n,
    output logic [GPIO_OUT_W-1:0]                  gpioOutput,
    output logic [NUM_PLAYERS*STATE_WORDS*32-1:0]  vga_state
);

    localparam int c_BANK_WORDS = NUM_PLAYERS * STATE_WORDS;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0] w_addr_ext;
    logic [31:0] w_off_full;
    logic        w_in_win;
    logic [8:0]  w_off;
    logic        w_wr;

    assign w_addr_ext = 32'(address);
    assign w_off_full = w_addr_ext - 32'(IO_BASE);
    assign w_in_win   = (w_addr_ext >= 32'(IO_BASE)) && (w_off_full < 32'(WINDOW_WORDS));
    assign w_off      = w_off_full[8:0];
    assign w_wr       = wren && w_in_win;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [31:0]           r_shadow [c_BANK_WORDS];
    logic [31:0]           r_front  [c_BANK_WORDS];
    logic                  r_commit_pending;
    logic [31:0]           r_frame_cnt;
    logic [GPIO_OUT_W-1:0] r_gpio_out;
    logic [31:0]           r_data_out;
    logic                  r_hit;
    logic                  r_vs_meta;
    logic                  r_vs_sync;
    logic                  r_vs_prev;
    logic                  w_vs_pulse;
    logic [31:0]           w_rdata;

    // Only the player slices of gpio feed debouncers; the rest is spare
    logic w_unused_gpio;
    assign w_unused_gpio = ^gpio;

    // ------------------------------------------------------------------
    // Per-player button debouncers
    // ------------------------------------------------------------------
    logic [BTN_W-1:0] w_level    [NUM_PLAYERS];
    logic [BTN_W-1:0] w_edges    [NUM_PLAYERS];
    logic [BTN_W-1:0] w_clr      [NUM_PLAYERS];
    logic [31:0]      w_btn_word [NUM_PLAYERS];

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        assign w_clr[p] = (w_wr && (w_off == OFF_BTN + 9'(p))) ? data_in[16 +: BTN_W] : '0;

        button_debouncer #(
            .BTN_W        (BTN_W),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debouncer (
            .clock   (clock),
            .reset   (reset),
            .btn_raw (gpio[p*BTN_W +: BTN_W]),
            .clr     (w_clr[p]),
            .level   (w_level[p]),
            .edges   (w_edges[p])
        );

        assign w_btn_word[p] = pack_btn(16'(w_level[p]), 16'(w_edges[p]));
    end

    // ------------------------------------------------------------------
    // vsync synchroniser and falling-edge pulse
    // ------------------------------------------------------------------
    // Two flops for metastability, a third to detect the falling edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_meta <= vsync_n;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_vs_pulse = r_vs_prev && !r_vs_sync;

    // ------------------------------------------------------------------
    // Shadow / front banks
    // ------------------------------------------------------------------
    // Front copies the pre-write shadow so a write in the swap cycle waits a frame
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < c_BANK_WORDS; i++) begin
                r_shadow[i] <= '0;
                r_front[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < c_BANK_WORDS; i++) begin
                if (w_vs_pulse && r_commit_pending) begin
                    r_front[i] <= r_shadow[i];
                end
                if (w_wr && (w_off == OFF_STATE + 9'(i))) begin
                    r_shadow[i] <= data_in;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit flag, frame counter, gpio output
    // ------------------------------------------------------------------
    // A commit request landing in the swap cycle survives to the next frame
    always_ff @(posedge clock) begin
        if (reset) begin
            r_commit_pending <= 1'b0;
            r_frame_cnt      <= '0;
            r_gpio_out       <= '0;
        end else begin
            if (w_wr && (w_off == OFF_COMMIT) && data_in[0]) begin
                r_commit_pending <= 1'b1;
            end else if (w_vs_pulse) begin
                r_commit_pending <= 1'b0;
            end
            if (w_vs_pulse) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            if (w_wr && (w_off == OFF_GPIO)) begin
                r_gpio_out <= data_in[GPIO_OUT_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // Combinational select of the addressed word; unmapped offsets read 0
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < c_BANK_WORDS; i++) begin
            if (w_off == OFF_STATE + 9'(i)) begin
                w_rdata = r_shadow[i];
            end
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_off == OFF_BTN + 9'(p)) begin
                w_rdata = w_btn_word[p];
            end
        end
        if (w_off == OFF_COMMIT) begin
            w_rdata = {31'b0, r_commit_pending};
        end
        if (w_off == OFF_FRAME) begin
            w_rdata = r_frame_cnt;
        end
        if (w_off == OFF_GPIO) begin
            w_rdata = 32'(r_gpio_out);
        end
    end

    // Registered read data and hit, one cycle behind the address
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out <= '0;
            r_hit      <= 1'b0;
        end else begin
            r_data_out <= w_in_win ? w_rdata : '0;
            r_hit      <= w_in_win;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < c_BANK_WORDS; i++) begin : g_front
        assign vga_state[i*32 +: 32] = r_front[i];
    end

    assign data_out   = r_data_out;
    assign hit        = r_hit;
    assign gpioOutput = r_gpio_out;

endmodule : mmio_player_hub
`default_nettype wire
